// File: rtl/ma_ldst_unit.sv
// Memory-access stage load/store unit between EX and a 4-lane 1R1W data RAM with registered read address.
// Build option: define MISALIGN_TRAP_EN to trap misaligned accesses (blocked write / no load result, misalign_exc pulse).
module ma_ldst_unit #(
    parameter int DWIDTH = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              cmd_ld_ex,
    input  logic              cmd_st_ex,
    input  logic [2:0]        ldst_code_ex,
    input  logic [31:0]       ldst_adr_ex,
    input  logic [31:0]       st_data_ex,
    output logic [DWIDTH-1:0] ram_radr,
    input  logic [31:0]       ram_rdata,
    output logic [DWIDTH-1:0] ram_wadr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_wen,
    output logic [31:0]       ld_data_wb,
    output logic              ld_valid_wb,
    output logic              misalign_exc
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [DWIDTH-1:0] word_adr;
    logic [1:0]        boff;
    logic              ld_code_ok;
    logic              st_code_ok;
    logic              misaligned;
    logic              st_cmd;
    logic              ld_cmd;
    logic              st_go;
    logic              ld_go;

    logic              ld_pend;
    logic [2:0]        code_q;
    logic [1:0]        boff_q;
    logic [DWIDTH-1:0] radr_q;

    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       ld_result;

    // Upper address bits beyond the RAM's reach are intentionally dropped.
    logic unused_adr_bits;
    assign unused_adr_bits = ^ldst_adr_ex[31:DWIDTH+2];

    assign word_adr = ldst_adr_ex[DWIDTH+1:2];
    assign boff     = ldst_adr_ex[1:0];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        ld_code_ok = 1'b0;
        st_code_ok = 1'b0;
        case (ldst_code_ex)
            F3_B, F3_H, F3_W: begin
                ld_code_ok = 1'b1;
                st_code_ok = 1'b1;
            end
            F3_BU, F3_HU: ld_code_ok = 1'b1;
            default: ;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign misaligned = (ldst_code_ex[1:0] == 2'b01 && boff[0]) ||
                        (ldst_code_ex[1:0] == 2'b10 && boff != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // A store issued together with a load wins; the load is dropped.
    assign st_cmd = cmd_st_ex && !stall && st_code_ok;
    assign ld_cmd = cmd_ld_ex && !cmd_st_ex && !stall && ld_code_ok;
    assign st_go  = st_cmd && !misaligned;
    assign ld_go  = ld_cmd && !misaligned;

    assign ram_wadr = word_adr;
    assign ram_radr = ld_go ? word_adr : radr_q;

    always_comb begin
        ram_wen   = 4'b0000;
        ram_wdata = st_data_ex;
        case (ldst_code_ex[1:0])
            2'b00: begin
                ram_wen   = 4'b0001 << boff;
                ram_wdata = {4{st_data_ex[7:0]}};
            end
            2'b01: begin
                ram_wen   = 4'b0011 << {boff[1], 1'b0};
                ram_wdata = {2{st_data_ex[15:0]}};
            end
            default: ram_wen = 4'b1111;
        endcase
        if (!st_go) ram_wen = 4'b0000;
    end

    always_comb begin
        lane_b = ram_rdata[{boff_q, 3'b000} +: 8];
        lane_h = boff_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (code_q)
            F3_B:    ld_result = {{24{lane_b[7]}}, lane_b};
            F3_BU:   ld_result = {24'h000000, lane_b};
            F3_H:    ld_result = {{16{lane_h[15]}}, lane_h};
            F3_HU:   ld_result = {16'h0000, lane_h};
            default: ld_result = ram_rdata;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_pend     <= 1'b0;
            code_q      <= 3'b000;
            boff_q      <= 2'b00;
            radr_q      <= '0;
            ld_data_wb  <= 32'h0000_0000;
            ld_valid_wb <= 1'b0;
        end else if (!stall) begin
            ld_pend     <= ld_go;
            if (ld_go) begin
                code_q <= ldst_code_ex;
                boff_q <= boff;
                radr_q <= word_adr;
            end
            ld_valid_wb <= ld_pend;
            if (ld_pend) ld_data_wb <= ld_result;
        end else begin
            ld_valid_wb <= 1'b0;
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) misalign_exc <= 1'b0;
        else     misalign_exc <= (st_cmd || ld_cmd) && misaligned;
    end
`else
    assign misalign_exc = 1'b0;
`endif

endmodule

// File: tb/tb_ma_ldst_unit.sv
// Self-checking bench for ma_ldst_unit: directed scenarios, then randomized traffic against a byte-level memory model.
// Honours MISALIGN_TRAP_EN the same way as the design.
module tb_ma_ldst_unit;

    localparam int DW = 12;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0;
    logic          cmd_ld_ex = 1'b0;
    logic          cmd_st_ex = 1'b0;
    logic [2:0]    ldst_code_ex = 3'b000;
    logic [31:0]   ldst_adr_ex = 32'h0;
    logic [31:0]   st_data_ex = 32'h0;
    logic [DW-1:0] ram_radr;
    logic [31:0]   ram_rdata;
    logic [DW-1:0] ram_wadr;
    logic [31:0]   ram_wdata;
    logic [3:0]    ram_wen;
    logic [31:0]   ld_data_wb;
    logic          ld_valid_wb;
    logic          misalign_exc;

    int checks = 0;
    int errors = 0;

    ma_ldst_unit #(.DWIDTH(DW)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .cmd_ld_ex(cmd_ld_ex), .cmd_st_ex(cmd_st_ex),
        .ldst_code_ex(ldst_code_ex), .ldst_adr_ex(ldst_adr_ex), .st_data_ex(st_data_ex),
        .ram_radr(ram_radr), .ram_rdata(ram_rdata),
        .ram_wadr(ram_wadr), .ram_wdata(ram_wdata), .ram_wen(ram_wen),
        .ld_data_wb(ld_data_wb), .ld_valid_wb(ld_valid_wb), .misalign_exc(misalign_exc)
    );

    always #5 clk = ~clk;

    // Byte-lane RAM with registered read address (read-before-write on a shared edge).
    logic [31:0] mem [0:(1<<DW)-1];
    always @(posedge clk) begin
        ram_rdata <= mem[ram_radr];
        for (int i = 0; i < 4; i++)
            if (ram_wen[i]) mem[ram_wadr][8*i +: 8] <= ram_wdata[8*i +: 8];
    end

    // Reference: flat byte memory, program-order semantics.
    logic [7:0]  ref_mem [0:255];
    logic [31:0] exp_q [$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic ld, input logic st, input logic [2:0] code,
                       input logic [31:0] adr, input logic [31:0] data);
        cmd_ld_ex    = ld;
        cmd_st_ex    = st;
        ldst_code_ex = code;
        ldst_adr_ex  = adr;
        st_data_ex   = data;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    task automatic store(input logic [2:0] code, input logic [31:0] adr, input logic [31:0] data);
        drv(1'b0, 1'b1, code, adr, data);
        tick();
        idle();
    endtask

    // Issue one load and check the 2-edge latency and the result.
    task automatic load_chk(input string tag, input logic [2:0] code, input logic [31:0] adr,
                            input logic [31:0] exp);
        drv(1'b1, 1'b0, code, adr, 32'h0);
        tick();
        idle();
        check({tag, "_v1"}, {31'd0, ld_valid_wb}, 32'd0);
        tick();
        check({tag, "_v2"}, {31'd0, ld_valid_wb}, 32'd1);
        check({tag, "_data"}, ld_data_wb, exp);
    endtask

    function automatic int acc_size(input logic [2:0] code);
        if (code[1:0] == 2'b00) return 1;
        if (code[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] code, input int adr);
        int          size;
        int          base;
        logic [31:0] v;
        size = acc_size(code);
        base = adr - adr % size;
        v = 32'h0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[base + i];
        if (!code[2] && size < 4 && v[8*size-1])
            for (int i = 8*size; i < 32; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] code, input int adr, input logic [31:0] data);
        int size;
        int base;
        size = acc_size(code);
        base = adr - adr % size;
        for (int i = 0; i < size; i++) ref_mem[base + i] = data[8*i +: 8];
    endtask

    initial begin
        logic        r_ld, r_st, r_stall, st_ok, ld_ok, mis, pend_exp, exp_valid, exp_mis;
        logic [2:0]  r_code;
        logic [31:0] r_data, w;
        logic [3:0]  exp_wen;
        int          r_adr, size, sel;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, ld_valid_wb}, 32'd0);
        check("rst_data", ld_data_wb, 32'd0);
        check("rst_mis", {31'd0, misalign_exc}, 32'd0);
        check("rst_wen", {28'd0, ram_wen}, 32'd0);
        check("rst_radr", {20'd0, ram_radr}, 32'd0);
        rst = 1'b0;

        // Reset while a load is pending discards it
        drv(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        tick();
        idle();
        #2 rst = 1'b1;
        #1;
        check("rstld_valid", {31'd0, ld_valid_wb}, 32'd0);
        check("rstld_data", ld_data_wb, 32'd0);
        check("rstld_wen", {28'd0, ram_wen}, 32'd0);
        rst = 1'b0;
        tick();
        check("rstld_v1", {31'd0, ld_valid_wb}, 32'd0);
        tick();
        check("rstld_v2", {31'd0, ld_valid_wb}, 32'd0);
        check("rstld_data2", ld_data_wb, 32'd0);

        // SB / LB / LBU
        store(3'b010, 32'h4, 32'h0);
        drv(1'b0, 1'b1, 3'b000, 32'h6, 32'h1234_56A5);
        @(negedge clk);
        check("sb_wadr", {20'd0, ram_wadr}, 32'd1);
        check("sb_wen", {28'd0, ram_wen}, 32'h4);
        check("sb_wdata", ram_wdata, 32'hA5A5_A5A5);
        tick();
        idle();
        load_chk("lb", 3'b000, 32'h6, 32'hFFFF_FFA5);
        load_chk("lbu", 3'b100, 32'h6, 32'h0000_00A5);

        // SH / LH / LHU
        drv(1'b0, 1'b1, 3'b001, 32'hA, 32'h0000_8001);
        @(negedge clk);
        check("sh_wen", {28'd0, ram_wen}, 32'hC);
        check("sh_wdata", ram_wdata, 32'h8001_8001);
        tick();
        idle();
        load_chk("lh", 3'b001, 32'hA, 32'hFFFF_8001);
        load_chk("lhu", 3'b101, 32'hA, 32'h0000_8001);

        // Back-to-back LW
        store(3'b010, 32'h10, 32'h11);
        store(3'b010, 32'h14, 32'h22);
        store(3'b010, 32'h18, 32'h33);
        drv(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        tick();
        check("b2b_v0", {31'd0, ld_valid_wb}, 32'd0);
        drv(1'b1, 1'b0, 3'b010, 32'h14, 32'h0);
        tick();
        check("b2b_v1", {31'd0, ld_valid_wb}, 32'd1);
        check("b2b_d1", ld_data_wb, 32'h11);
        drv(1'b1, 1'b0, 3'b010, 32'h18, 32'h0);
        tick();
        check("b2b_v2", {31'd0, ld_valid_wb}, 32'd1);
        check("b2b_d2", ld_data_wb, 32'h22);
        idle();
        tick();
        check("b2b_v3", {31'd0, ld_valid_wb}, 32'd1);
        check("b2b_d3", ld_data_wb, 32'h33);
        tick();
        check("b2b_v4", {31'd0, ld_valid_wb}, 32'd0);

        // LW held across a 3-cycle stall; a store offered during stall must be ignored
        store(3'b010, 32'h20, 32'hCAFE_F00D);
        drv(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        @(negedge clk);
        check("stl_radr0", {20'd0, ram_radr}, 32'd8);
        tick();
        stall = 1'b1;
        drv(1'b0, 1'b1, 3'b010, 32'h20, 32'h5555_5555);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stl_radr", {20'd0, ram_radr}, 32'd8);
            check("stl_wen", {28'd0, ram_wen}, 32'd0);
            tick();
            check("stl_valid", {31'd0, ld_valid_wb}, 32'd0);
        end
        stall = 1'b0;
        idle();
        tick();
        check("stl_v_rel", {31'd0, ld_valid_wb}, 32'd1);
        check("stl_data", ld_data_wb, 32'hCAFE_F00D);
        tick();
        check("stl_v_dup", {31'd0, ld_valid_wb}, 32'd0);
        check("stl_hold", ld_data_wb, 32'hCAFE_F00D);

        // Misaligned SW to 0x22 and LH from 0x0B
        drv(1'b0, 1'b1, 3'b010, 32'h22, 32'hDEAD_BEEF);
        @(negedge clk);
`ifdef MISALIGN_TRAP_EN
        check("msw_wen", {28'd0, ram_wen}, 32'd0);
        tick();
        idle();
        check("msw_exc1", {31'd0, misalign_exc}, 32'd1);
        tick();
        check("msw_exc2", {31'd0, misalign_exc}, 32'd0);
        load_chk("msw_lw", 3'b010, 32'h20, 32'hCAFE_F00D);
        drv(1'b1, 1'b0, 3'b001, 32'hB, 32'h0);
        tick();
        idle();
        check("mlh_exc", {31'd0, misalign_exc}, 32'd1);
        tick();
        check("mlh_valid", {31'd0, ld_valid_wb}, 32'd0);
`else
        check("msw_wen", {28'd0, ram_wen}, 32'hF);
        check("msw_wadr", {20'd0, ram_wadr}, 32'd8);
        tick();
        idle();
        check("msw_exc", {31'd0, misalign_exc}, 32'd0);
        load_chk("msw_lw", 3'b010, 32'h20, 32'hDEAD_BEEF);
        load_chk("mlh", 3'b001, 32'hB, 32'hFFFF_8001);
`endif

        // Simultaneous load and store: store wins, no load result
        drv(1'b1, 1'b1, 3'b000, 32'h30, 32'h77);
        @(negedge clk);
        check("ldst_wen", {28'd0, ram_wen}, 32'h1);
        tick();
        idle();
        tick();
        check("ldst_valid", {31'd0, ld_valid_wb}, 32'd0);

        // Reserved funct3 codes do nothing
        drv(1'b0, 1'b1, 3'b011, 32'h30, 32'hFFFF_FFFF);
        @(negedge clk);
        check("inv_wen", {28'd0, ram_wen}, 32'd0);
        tick();
        drv(1'b1, 1'b0, 3'b110, 32'h30, 32'h0);
        tick();
        idle();
        tick();
        check("inv_valid", {31'd0, ld_valid_wb}, 32'd0);

        // Randomized traffic over words 0..15
        for (int wi = 0; wi < 16; wi++) begin
            w = $urandom;
            store(3'b010, 32'(4 * wi), w);
            ref_store(3'b010, 4 * wi, w);
        end
        tick();
        pend_exp = 1'b0;
        for (int n = 0; n < 600; n++) begin
            sel     = $urandom_range(0, 9);
            r_ld    = (sel < 5) || (sel == 9);
            r_st    = (sel >= 5);
            r_stall = ($urandom_range(0, 4) == 0);
            r_code  = 3'($urandom_range(0, 7));
            r_adr   = $urandom_range(0, 63);
            r_data  = $urandom;
            if (n >= 596) begin
                r_ld = 1'b0;
                r_st = 1'b0;
                r_stall = 1'b0;
            end
            stall = r_stall;
            drv(r_ld, r_st, r_code, 32'(r_adr), r_data);

            size  = acc_size(r_code);
            mis   = TRAP && (r_adr % size != 0);
            st_ok = !r_stall && r_st && (r_code == 3'b000 || r_code == 3'b001 || r_code == 3'b010);
            ld_ok = !r_stall && r_ld && !r_st &&
                    (r_code == 3'b000 || r_code == 3'b001 || r_code == 3'b010 ||
                     r_code == 3'b100 || r_code == 3'b101);
            exp_mis = (st_ok || ld_ok) && mis;
            exp_wen = (st_ok && !mis) ?
                      4'(((1 << size) - 1) << ((r_adr % 4) - (r_adr % size))) : 4'b0000;

            @(negedge clk);
            check("rnd_wen", {28'd0, ram_wen}, {28'd0, exp_wen});

            if (r_stall) begin
                exp_valid = 1'b0;
            end else begin
                exp_valid = pend_exp;
                pend_exp  = ld_ok && !mis;
                if (ld_ok && !mis) exp_q.push_back(ref_load(r_code, r_adr));
                if (st_ok && !mis) ref_store(r_code, r_adr, r_data);
            end
            tick();
            check("rnd_valid", {31'd0, ld_valid_wb}, {31'd0, exp_valid});
            check("rnd_mis", {31'd0, misalign_exc}, {31'd0, exp_mis});
            if (exp_valid && exp_q.size() > 0)
                check("rnd_data", ld_data_wb, exp_q.pop_front());
        end
        stall = 1'b0;
        idle();
        check("rnd_drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ma_ldst_unit.md
Name: ma_ldst_unit

Overview:
- Memory-access stage load/store unit; sits between the EX stage and the byte-lane 1R1W data RAM (4 byte lanes, registered read address).
- Store path: converts EX address/data/funct3 into RAM word address, byte-lane enables and lane-replicated write data.
- Load path: tracks each load across the RAM's one-cycle read latency, then extracts, aligns and sign/zero-extends the read data into a registered result for WB.
- Holds the RAM read address and load state stable under pipeline stall.

Parameters:
- DWIDTH, 12, RAM word-address width; byte address bits [DWIDTH+1:2] select the word.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- stall  in  1  global pipeline stall; freezes this stage
- cmd_ld_ex  in  1  load issued from EX this cycle
- cmd_st_ex  in  1  store issued from EX this cycle
- ldst_code_ex  in  3  RV32I funct3 of the access
- ldst_adr_ex  in  32  byte address (ALU result)
- st_data_ex  in  32  store source data (rs2)
- ram_radr  out  DWIDTH  RAM read word address
- ram_rdata  in  32  RAM read data (valid one cycle after ram_radr is sampled)
- ram_wadr  out  DWIDTH  RAM write word address
- ram_wdata  out  32  RAM write data, lane-replicated
- ram_wen  out  4  RAM byte-lane write enables
- ld_data_wb  out  32  extended load result to WB
- ld_valid_wb  out  1  ld_data_wb is a new load result
- misalign_exc  out  1  misaligned-access pulse (see Optional Feature)

Behaviour:
- Reset (async, rst=1):
  - Pipeline registers cleared: ld_pend=0, code_q=0, boff_q=0, radr_q=0.
  - Outputs: ld_data_wb=0, ld_valid_wb=0, misalign_exc=0, ram_wen=0.
- Reset mid-load: the pending load is discarded; no ld_valid_wb pulse follows.
- Decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other funct3 is a no-op: no write, no load result.
- Store (combinational, qualified by !stall):
  - ram_wadr = adr[DWIDTH+1:2].
  - SB: wen = 4'b0001 << adr[1:0]; wdata = {4{st[7:0]}}.
  - SH: wen = 4'b0011 << {adr[1],1'b0}; wdata = {2{st[15:0]}}.
  - SW: wen = 4'b1111; wdata = st.
  - stall=1 forces wen=0.
- Load pipeline:
  - Cycle N, cmd_ld_ex & !stall: ram_radr = adr[DWIDTH+1:2]. At the edge, capture ld_pend=1, code_q, boff_q=adr[1:0], radr_q.
  - Cycle N+1: extract from ram_rdata.
    - Byte select: boff_q. Halfword select: boff_q[1].
    - LB/LH sign-extend; LBU/LHU zero-extend; LW pass-through.
  - Edge ending N+1: ld_data_wb <= result; ld_valid_wb <= 1 for exactly one cycle. Issue-to-ld_valid_wb latency is 2 edges.
- Read-address mux:
  - No new unstalled load: ram_radr = radr_q. This keeps RAM output stable for a pending or stalled load.
- Stall:
  - All internal registers hold.
  - ld_valid_wb deasserts after one cycle; ld_data_wb holds its value.
  - ram_radr = radr_q; ram_wen = 0; EX commands are ignored.
  - After stall releases, a pending load completes one edge later with the correct data.
- Back-to-back loads: one load per cycle, fully pipelined.
- Load followed by store to the same word:
  - The RAM's registered read address returns the pre-store data for the earlier load.
  - This unit adds no forwarding.
- Simultaneous cmd_ld_ex and cmd_st_ex (illegal): store wins; load is dropped (ld_pend=0).

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Misaligned access is detected: LH/LHU/SH with adr[0]=1, or LW/SW with adr[1:0]!=0.
  - Such a store forces wen=0.
  - Such a load sets no ld_valid_wb.
  - misalign_exc is registered and pulses 1 for one cycle at the edge after issue.
- Undefined:
  - No check. Low offset bits below the access size are ignored: SH/LH use adr[1] only; SW/LW ignore adr[1:0].
  - misalign_exc is tied 0.

Test Plan:
- Reset during pending load: LW issued, rst pulses before the next edge -> ld_valid_wb stays 0 and all outputs are 0.
- SB to 0x0000_0006 with st=0x1234_56A5 -> ram_wadr=1, wen=4'b0100, wdata=0xA5A5_A5A5. Then LB from 0x6 -> ld_data_wb=0xFFFF_FFA5. LBU -> 0x0000_00A5, with ld_valid_wb 2 edges after issue.
- SH 0x8001 to 0x0A, then LH and LHU from 0x0A -> ram_wen=4'b1100; LH gives 0xFFFF_8001, LHU gives 0x0000_8001.
- Back-to-back LW from 0x10, 0x14, 0x18 (preloaded 0x11, 0x22, 0x33) -> three consecutive ld_valid_wb cycles, data in order.
- LW from 0x20 then stall held 3 cycles -> ram_radr stays 8, wen=0. Data appears one edge after stall drops with the correct value; no duplicate valid.
- With MISALIGN_TRAP_EN: SW to 0x22 -> wen=0, misalign_exc=1 for one cycle, RAM unchanged. Without the macro: the same SW writes word 8 with wen=4'b1111.
